ysyx_23060096_gpr_file: RTL and testbench
=========================================

Name: ysyx_23060096_gpr_file

Overview:
- Parametrised general-purpose register file for the NPC core, replacing the fixed 32-entry, fixed-width register file.
- Provides 2 combinational read ports, 1 write port, x0 hardwired to zero, write-to-read bypass and a per-register busy scoreboard for hazard detection.
- After reset, a sequential clear engine zeroes the array one entry per cycle and holds `ready` low until it finishes.
- Sits between decode (reads, issue marking) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers; power of two, 2..64.
- AW, 5, index width; must equal log2(NREG).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ready  output  1  high once the clear sweep has completed.
- raddr1  input  AW  read port 1 index.
- rdata1  output  XLEN  read port 1 data.
- raddr2  input  AW  read port 2 index.
- rdata2  output  XLEN  read port 2 data.
- w_en  input  1  writeback write enable.
- waddr  input  AW  write index.
- wdata  input  XLEN  write data.
- iss_en  input  1  issue strobe; marks iss_rd busy.
- iss_rd  input  AW  destination register of the issuing instruction.
- busy1  output  1  register raddr1 has a write pending.
- busy2  output  1  register raddr2 has a write pending.

Behaviour:
- Reset is asynchronous and active-high; one clock domain (`clk`). While `rst` is high:
  - state=CLEAR, clr_idx=1, `ready`=0, all busy bits=0.
  - The array itself is not reset.
- FSM, two states:
  - CLEAR: writes rf[clr_idx]=0 each cycle and increments clr_idx. When clr_idx==NREG-1 is written, the FSM moves to RUN next cycle.
  - RUN: terminal state. Only `rst` re-enters CLEAR.
  - `ready` = (state==RUN). It rises exactly NREG-1 cycles after `rst` deasserts.
- During CLEAR:
  - w_en and iss_en are ignored.
  - rdata1/2 = 0.
  - busy1/2 = 0.
- Reads (RUN) are combinational, zero latency:
  - rdataN = 0 when raddrN==0.
  - Otherwise, if w_en && waddr==raddrN, rdataN = wdata (bypass).
  - Otherwise rdataN = rf[raddrN].
- Writes (RUN): rf[waddr] <= wdata on the clock edge when w_en && waddr!=0. Writes to x0 are discarded.
- Scoreboard (RUN), one busy bit per register:
  - Set: iss_en && iss_rd!=0 sets busy[iss_rd] at the next edge.
  - Clear: w_en clears busy[waddr] at the next edge.
  - Set and clear to the same index in the same cycle: set wins (a newer producer is in flight).
  - Sets and clears to different indices apply independently.
  - busy[0] is constant 0.
- Busy outputs are combinational: busyN = busy[raddrN] && !(w_en && waddr==raddrN). A same-cycle writeback satisfies the hazard, consistent with the bypass.
- Reset asserted mid-sweep or mid-operation: the FSM immediately returns to CLEAR with clr_idx=1, and all busy bits are cleared.
- Width rules:
  - No sign or zero extension inside the block; XLEN is passed through unchanged.
  - clr_idx is AW bits and never wraps, because the FSM leaves CLEAR at NREG-1.

Optional Feature:
- Macro: YSYX_23060096_GPR_DEBUG_PORT_EN.
- When defined:
  - Adds input `dbg_raddr` [AW] and output `dbg_rdata` [XLEN].
  - dbg_rdata = rf[dbg_raddr] directly, with no bypass; returns 0 for index 0 and while in CLEAR.
  - Used by difftest to snapshot architectural state.
- When not defined: the ports do not exist and no extra logic is generated.

Test Plan:
- Reset then idle, NREG=32 → `ready`=0 for exactly 31 cycles after `rst` falls, then 1. During the sweep rdata1 is 0 for every raddr1; after the sweep rf[1..31] read 0.
- Write in RUN: w_en=1, waddr=5, wdata=0xDEADBEEF with raddr1=5 → rdata1=0xDEADBEEF in the same cycle (bypass). Next cycle with w_en=0, rdata1 still reads 0xDEADBEEF.
- x0: w_en=1, waddr=0, wdata=0xFFFFFFFF; iss_en=1, iss_rd=0 → rdata1 (raddr1=0)=0 in both the write cycle and the next; busy1=0.
- Scoreboard: iss_en=1, iss_rd=7, then raddr2=7 → busy2=1. Later w_en=1, waddr=7 → busy2=0 combinationally in that cycle, and stays 0 after the edge.
- Set/clear collision: busy[9]=1, then in one cycle iss_en=1, iss_rd=9, w_en=1, waddr=9, wdata=0x12 → after the edge busy[9]=1 and rf[9]=0x12.
- Mid-run reset: write rf[3]=0xA5, set busy[4], then pulse `rst` asynchronously mid-cycle → `ready`=0 and busy2 (raddr2=4)=0 immediately. After the sweep rf[3] reads 0; writes issued during the sweep are not retained.

Source files
------------

// File: rtl/ysyx_23060096_gpr_file.sv
// NPC general-purpose register file: 2 read / 1 write ports, x0 = 0, write bypass,
// busy scoreboard and a post-reset clear sweep. Optional difftest port: YSYX_23060096_GPR_DEBUG_PORT_EN.
module ysyx_23060096_gpr_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic            w_en,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            busy1,
  output logic            busy2
`ifdef YSYX_23060096_GPR_DEBUG_PORT_EN
  ,
  input  logic [AW-1:0]   dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
`endif
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]      state_reg;
  logic [AW-1:0]   clr_idx_reg;
  logic            run;
  logic [XLEN-1:0] rf_mem [NREG];
  logic            rf_we;
  logic [AW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [AW-1:0]   rd_addr [2];
  logic [XLEN-1:0] rd_data [2];
  logic            rd_busy [2];
  logic            wb_hit  [2];

  assign run   = (state_reg == ST_RUN);
  assign ready = run;

  // Sweep starts at 1 because x0 is never read from the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_idx_reg <= AW'(1);
    end else if (state_reg == ST_CLEAR) begin
      if (clr_idx_reg == AW'(NREG - 1)) begin
        state_reg <= ST_RUN;
      end else begin
        clr_idx_reg <= clr_idx_reg + AW'(1);
      end
    end
  end

  // Single physical write port shared by the clear sweep and writeback.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = waddr;
    rf_wd = wdata;
    if (!run) begin
      rf_we = 1'b1;
      rf_wa = clr_idx_reg;
      rf_wd = '0;
    end else begin
      rf_we = w_en && (waddr != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_wa] <= rf_wd;
    end
  end

  // Issue set takes priority over writeback clear on the same index.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    assign busy_next[gi] = (run && iss_en && (iss_rd == AW'(gi))) ? 1'b1 :
                           (run && w_en   && (waddr  == AW'(gi))) ? 1'b0 :
                           busy_reg[gi];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rd_addr[0] = raddr1;
  assign rd_addr[1] = raddr2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign wb_hit[gi] = w_en && (waddr == rd_addr[gi]);
    always_comb begin
      rd_data[gi] = '0;
      rd_busy[gi] = 1'b0;
      if (run && (rd_addr[gi] != '0)) begin
        rd_data[gi] = wb_hit[gi] ? wdata : rf_mem[rd_addr[gi]];
        rd_busy[gi] = busy_reg[rd_addr[gi]] && !wb_hit[gi];
      end
    end
  end

  assign rdata1 = rd_data[0];
  assign rdata2 = rd_data[1];
  assign busy1  = rd_busy[0];
  assign busy2  = rd_busy[1];

`ifdef YSYX_23060096_GPR_DEBUG_PORT_EN
  assign dbg_rdata = (run && (dbg_raddr != '0)) ? rf_mem[dbg_raddr] : '0;
`endif

endmodule

// File: tb/tb_ysyx_23060096_gpr_file.sv
// Randomized bench for ysyx_23060096_gpr_file against an architectural model
// (register array, busy set, and cycles elapsed since reset release).
module tb_ysyx_23060096_gpr_file;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            ready;
  logic [AW-1:0]   raddr1, raddr2, waddr, iss_rd;
  logic [XLEN-1:0] rdata1, rdata2, wdata;
  logic            w_en, iss_en, busy1, busy2;
`ifdef YSYX_23060096_GPR_DEBUG_PORT_EN
  logic [XLEN-1:0] dbg_rdata;
`endif

  always #5 clk = ~clk;

  ysyx_23060096_gpr_file #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .w_en(w_en), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_rd(iss_rd), .busy1(busy1), .busy2(busy2)
`ifdef YSYX_23060096_GPR_DEBUG_PORT_EN
    , .dbg_raddr(raddr1), .dbg_rdata(dbg_rdata)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_rf   [NREG];
  bit              m_busy [NREG];
  int              cyc;   // rising edges seen with rst low since the last reset

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_run();
    return cyc >= NREG - 1;
  endfunction

  function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
    if (!m_run() || a == 0) return '0;
    if (w_en && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return m_run() && m_busy[a] && !(w_en && waddr == a);
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < NREG; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    w_en = 0; iss_en = 0; waddr = '0; wdata = '0; iss_rd = '0;
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances the model.
  task automatic cycle();
    #2;
    check("ready", ready, m_run());
    check("rdata1", rdata1, exp_rdata(raddr1));
    check("rdata2", rdata2, exp_rdata(raddr2));
    check("busy1", busy1, exp_busy(raddr1));
    check("busy2", busy2, exp_busy(raddr2));
`ifdef YSYX_23060096_GPR_DEBUG_PORT_EN
    check("dbg_rdata", dbg_rdata, (m_run() && raddr1 != 0) ? m_rf[raddr1] : '0);
`endif
    @(posedge clk);
    if (m_run()) begin
      if (w_en && waddr != 0) m_rf[waddr] = wdata;
      if (w_en) m_busy[waddr] = 1'b0;
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
    if (cyc < NREG - 1) cyc++;
    #1;
  endtask

  task automatic rand_inputs(input int hi);
    raddr1 = AW'($urandom_range(0, hi));
    raddr2 = AW'($urandom_range(0, hi));
    w_en   = 1'($urandom_range(0, 1));
    waddr  = AW'($urandom_range(0, hi));
    wdata  = $urandom;
    iss_en = 1'($urandom_range(0, 1));
    iss_rd = AW'($urandom_range(0, hi));
  endtask

  initial begin
    rst = 1'b1;
    raddr1 = '0; raddr2 = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", ready, 1'b0);
    check("busy1_in_reset", busy1, 1'b0);
    rst = 1'b0;

    // Sweep: traffic must be ignored and reads must return zero.
    for (int i = 0; i < NREG - 1; i++) begin
      rand_inputs(NREG - 1);
      cycle();
    end
    idle();
    for (int a = 1; a < NREG; a++) begin
      raddr1 = AW'(a);
      raddr2 = AW'(NREG - a);
      cycle();
    end

    // Write with same-cycle bypass, then plain read.
    raddr1 = 5; w_en = 1; waddr = 5; wdata = 32'hDEADBEEF;
    cycle();
    idle();
    cycle();
    check("rf5_after_write", rdata1, 32'hDEADBEEF);

    // x0 write and issue are discarded.
    raddr1 = 0; w_en = 1; waddr = 0; wdata = 32'hFFFFFFFF; iss_en = 1; iss_rd = 0;
    cycle();
    idle();
    cycle();

    // Scoreboard set then writeback clear.
    iss_en = 1; iss_rd = 7;
    cycle();
    idle(); raddr2 = 7;
    cycle();
    check("busy7_set", busy2, 1'b1);
    w_en = 1; waddr = 7; wdata = 32'h77;
    cycle();
    idle();
    cycle();

    // Set/clear collision: set wins, data still written.
    iss_en = 1; iss_rd = 9;
    cycle();
    iss_en = 1; iss_rd = 9; w_en = 1; waddr = 9; wdata = 32'h12; raddr1 = 9; raddr2 = 9;
    cycle();
    idle();
    cycle();
    check("busy9_collision", busy1, 1'b1);
    check("rf9_collision", rdata1, 32'h12);

    // Random traffic: dense low indices, then full range.
    for (int i = 0; i < 300; i++) begin
      rand_inputs(7);
      cycle();
    end
    for (int i = 0; i < 300; i++) begin
      rand_inputs(NREG - 1);
      cycle();
    end

    // Mid-run asynchronous reset.
    idle(); w_en = 1; waddr = 3; wdata = 32'hA5;
    cycle();
    idle(); iss_en = 1; iss_rd = 4;
    cycle();
    idle(); raddr2 = 4;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("ready_async_rst", ready, 1'b0);
    check("busy4_async_rst", busy2, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NREG - 1; i++) begin
      raddr1 = 3; raddr2 = 4; w_en = 1; waddr = 3; wdata = $urandom;
      iss_en = 1; iss_rd = 4;
      cycle();
    end
    idle(); raddr1 = 3; raddr2 = 4;
    cycle();
    check("rf3_after_rst", rdata1, '0);
    check("busy4_after_rst", busy2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
